ptw_axi_arbiter: RTL
====================

Name: ptw_axi_arbiter

Overview:
- Shares one AXI4 read master between the ITLB and DTLB page-table walkers.
- Each TLB issues single-beat 64-bit PTE reads as one-cycle ADDR_TO_AXIM_VALID pulses. The arbiter captures each pulse, arbitrates round-robin, and runs one outstanding AXI read at a time.
- The returned PTE goes back to the originating TLB as a one-cycle DATA_FROM_AXIM_VALID pulse.
- Position: directly downstream of ITLB/DTLB, upstream of the system AXI interconnect.

Parameters:
ADDR_WIDTH, 64, PTE address and ARADDR width
DATA_WIDTH, 64, PTE / RDATA width (one PTE per beat)
AXI_ID_WIDTH, 4, ARID/RID width
AXI_ID, 0, constant ARID value; RID is not checked

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
ITLB_ADDR_VALID  in  1  one-cycle PTE read request from ITLB
ITLB_ADDR  in  ADDR_WIDTH  PTE address, valid with ITLB_ADDR_VALID
ITLB_DATA_VALID  out  1  one-cycle PTE return pulse to ITLB
ITLB_DATA  out  DATA_WIDTH  PTE to ITLB, valid with ITLB_DATA_VALID
ITLB_ACCESS_FAULT  out  1  one-cycle bus-error pulse to ITLB
DTLB_ADDR_VALID  in  1  as ITLB_ADDR_VALID, for DTLB
DTLB_ADDR  in  ADDR_WIDTH  as ITLB_ADDR, for DTLB
DTLB_DATA_VALID  out  1  as ITLB_DATA_VALID, for DTLB
DTLB_DATA  out  DATA_WIDTH  as ITLB_DATA, for DTLB
DTLB_ACCESS_FAULT  out  1  as ITLB_ACCESS_FAULT, for DTLB
M_ARVALID  out  1  AXI read address valid
M_ARREADY  in  1  AXI read address ready
M_ARADDR  out  ADDR_WIDTH  AXI read address
M_ARID  out  AXI_ID_WIDTH  constant AXI_ID
M_ARLEN  out  8  constant 0
M_ARSIZE  out  3  constant 3'b011
M_ARBURST  out  2  constant 2'b01
M_RVALID  in  1  AXI read data valid
M_RREADY  out  1  AXI read data ready
M_RDATA  in  DATA_WIDTH  AXI read data
M_RRESP  in  2  AXI read response
M_RLAST  in  1  AXI read last; ignored, single beat only

Behaviour:
- Reset (RSTN=0, asynchronous):
  - State goes to IDLE; both pending flags cleared; round-robin pointer set to favour ITLB.
  - All outputs 0: M_ARVALID, M_RREADY, M_ARADDR, both DATA_VALID, both ACCESS_FAULT, both DATA.
  - A transaction in flight is abandoned; reset is system-wide.
- Capture:
  - Each requester has a pending flag and an address register.
  - XTLB_ADDR_VALID=1 sets the flag and stores {ADDR[ADDR_WIDTH-1:3],3'b000} at the next edge.
  - A pulse arriving while that requester is already pending or in flight is dropped.
  - A pulse arriving in the cycle its own DATA_VALID or ACCESS_FAULT is high is accepted.
- FSM states:
  - IDLE: when any request is visible (pending flag or same-cycle pulse), grant, load M_ARADDR, clear the granted flag, go to AR.
    - Only one requester: grant it.
    - Both requesters: grant the one not granted last, then update the pointer.
  - AR: M_ARVALID=1, M_ARADDR held stable. On M_ARREADY=1, go to R.
  - R: M_RREADY=1. On M_RVALID=1, go to RESP.
    - RRESP is OKAY (2'b00) or EXOKAY (2'b01): register RDATA into the granted XTLB_DATA.
    - Other RRESP values: flag a fault.
  - RESP: exactly one of XTLB_DATA_VALID or XTLB_ACCESS_FAULT for the granted requester is 1 for this cycle only, then IDLE.
- Latency, zero-wait bus:
  - Request pulse at cycle t → M_ARVALID=1 at t+1.
  - AR handshake at t+1 → M_RREADY=1 at t+2.
  - R handshake at t+2 → DATA_VALID=1 at t+3.
  - Minimum back-to-back grant spacing: RESP plus IDLE, i.e. next M_ARVALID two cycles after the RESP cycle.
- XTLB_DATA holds its last value after the pulse.
- M_ARVALID never drops without M_ARREADY.

Decomposition:
- Shared package ptw_pkg holds:
  - AXI constants: RESP_OKAY, RESP_EXOKAY, BURST_INCR, SIZE_8B.
  - FSM state encoding: IDLE, AR, R, RESP.
  - Requester index: REQ_ITLB=0, REQ_DTLB=1.
- Natural sub-module: ptw_req_capture, instantiated twice; holds the pending flag and address register.
- Arbiter FSM lives at the top.

Test Plan:
- Single ITLB read: ITLB pulse, ITLB_ADDR=0x8000_1007, ARREADY/RVALID immediate, RDATA=0x2000_04CF → M_ARADDR=0x8000_1000 at t+1; ITLB_DATA_VALID=1 at t+3 with ITLB_DATA=0x2000_04CF; DTLB outputs stay 0.
- Simultaneous requests: both pulse at t with 0x1000 and 0x2000 → ITLB served first, DTLB's AR issued after ITLB's RESP+IDLE; next simultaneous pair is served DTLB first.
- Backpressure: M_ARREADY low 5 cycles, M_RVALID delayed 7 cycles → M_ARVALID and M_ARADDR stable throughout; exactly one DATA_VALID pulse.
- Bus error: RRESP=2'b10 → DTLB_ACCESS_FAULT pulses for one cycle; DTLB_DATA_VALID stays 0.
- Duplicate pulse: second ITLB pulse while ITLB is in flight → dropped; only one AR observed.
- Async reset: RSTN low mid-R phase, not on a clock edge → all outputs 0 immediately; after release, fresh requests complete normally.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared definitions for the page-table-walker AXI read arbiter:
// AXI encodings, FSM states and requester indices.
package ptw_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'b011;

    localparam logic REQ_ITLB = 1'b0;
    localparam logic REQ_DTLB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        RESP
    } ptw_state_t;

    function automatic logic resp_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/ptw_req_capture.sv
// Holds one TLB's pending PTE read: a flag plus the 8-byte aligned address.
// A same-cycle pulse is made visible immediately so IDLE can grant without a bubble.
module ptw_req_capture #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  addr_valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  in_flight,
    input  logic                  clear,
    output logic                  visible,
    output logic [ADDR_WIDTH-1:0] req_addr
);

    logic                  pending;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic                  accept;

    assign addr_aligned = addr & ~{{(ADDR_WIDTH-3){1'b0}}, 3'b111};
    assign accept       = addr_valid && !pending && !in_flight;
    assign visible      = pending || accept;
    assign req_addr     = pending ? addr_q : addr_aligned;

    // A grant consumes either the stored request or the same-cycle pulse.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pending <= 1'b0;
            addr_q  <= '0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
            addr_q  <= addr_aligned;
        end
    end

endmodule

// File: rtl/ptw_axi_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AXI4 read master
// between the ITLB and DTLB page-table walkers.
module ptw_axi_arbiter
    import ptw_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int AXI_ID_WIDTH = 4,
    parameter int AXI_ID       = 0
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    ITLB_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0]   ITLB_ADDR,
    output logic                    ITLB_DATA_VALID,
    output logic [DATA_WIDTH-1:0]   ITLB_DATA,
    output logic                    ITLB_ACCESS_FAULT,
    input  logic                    DTLB_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0]   DTLB_ADDR,
    output logic                    DTLB_DATA_VALID,
    output logic [DATA_WIDTH-1:0]   DTLB_DATA,
    output logic                    DTLB_ACCESS_FAULT,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [AXI_ID_WIDTH-1:0] M_ARID,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST
);

    ptw_state_t            state;
    logic                  grant;
    logic                  favour_dtlb;
    logic                  pick;
    logic                  start_grant;
    logic                  itlb_visible;
    logic                  dtlb_visible;
    logic [ADDR_WIDTH-1:0] itlb_req_addr;
    logic [ADDR_WIDTH-1:0] dtlb_req_addr;
    logic                  itlb_in_flight;
    logic                  dtlb_in_flight;
    logic                  unused_rlast;

    assign M_ARID       = AXI_ID_WIDTH'(AXI_ID);
    assign M_ARLEN      = 8'd0;
    assign M_ARSIZE     = SIZE_8B;
    assign M_ARBURST    = BURST_INCR;
    // Every transfer is a single beat, so RLAST carries no information.
    assign unused_rlast = M_RLAST;

    assign itlb_in_flight = ((state == AR) || (state == R)) && (grant == REQ_ITLB);
    assign dtlb_in_flight = ((state == AR) || (state == R)) && (grant == REQ_DTLB);
    assign start_grant    = (state == IDLE) && (itlb_visible || dtlb_visible);

    ptw_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_itlb_capture (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .addr_valid (ITLB_ADDR_VALID),
        .addr       (ITLB_ADDR),
        .in_flight  (itlb_in_flight),
        .clear      (start_grant && (pick == REQ_ITLB)),
        .visible    (itlb_visible),
        .req_addr   (itlb_req_addr)
    );

    ptw_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_dtlb_capture (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .addr_valid (DTLB_ADDR_VALID),
        .addr       (DTLB_ADDR),
        .in_flight  (dtlb_in_flight),
        .clear      (start_grant && (pick == REQ_DTLB)),
        .visible    (dtlb_visible),
        .req_addr   (dtlb_req_addr)
    );

    // The round-robin pointer only moves when both walkers contend.
    always_comb begin
        pick = REQ_ITLB;
        if (itlb_visible && dtlb_visible) begin
            pick = favour_dtlb ? REQ_DTLB : REQ_ITLB;
        end else if (dtlb_visible) begin
            pick = REQ_DTLB;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state             <= IDLE;
            grant             <= REQ_ITLB;
            favour_dtlb       <= 1'b0;
            M_ARVALID         <= 1'b0;
            M_ARADDR          <= '0;
            M_RREADY          <= 1'b0;
            ITLB_DATA_VALID   <= 1'b0;
            ITLB_ACCESS_FAULT <= 1'b0;
            ITLB_DATA         <= '0;
            DTLB_DATA_VALID   <= 1'b0;
            DTLB_ACCESS_FAULT <= 1'b0;
            DTLB_DATA         <= '0;
        end else begin
            ITLB_DATA_VALID   <= 1'b0;
            ITLB_ACCESS_FAULT <= 1'b0;
            DTLB_DATA_VALID   <= 1'b0;
            DTLB_ACCESS_FAULT <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_grant) begin
                        grant     <= pick;
                        M_ARADDR  <= (pick == REQ_DTLB) ? dtlb_req_addr : itlb_req_addr;
                        M_ARVALID <= 1'b1;
                        state     <= AR;
                        if (itlb_visible && dtlb_visible) begin
                            favour_dtlb <= (pick == REQ_ITLB);
                        end
                    end
                end
                AR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (M_RVALID) begin
                        M_RREADY <= 1'b0;
                        state    <= RESP;
                        if (resp_ok(M_RRESP)) begin
                            if (grant == REQ_DTLB) begin
                                DTLB_DATA       <= M_RDATA;
                                DTLB_DATA_VALID <= 1'b1;
                            end else begin
                                ITLB_DATA       <= M_RDATA;
                                ITLB_DATA_VALID <= 1'b1;
                            end
                        end else if (grant == REQ_DTLB) begin
                            DTLB_ACCESS_FAULT <= 1'b1;
                        end else begin
                            ITLB_ACCESS_FAULT <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
